// File: rtl/date_calendar.sv
// date_calendar: day/month/year/weekday keeper for the digital clock.
// Advances one day per day_tick and accepts range-checked field loads
// from the shared set-mode data path. A load always wins over a tick.
module date_calendar #(
  parameter logic [2:0] WEEKDAY_RST = 3'd5
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       day_tick,
  input  logic       load,
  input  logic [1:0] sel,
  input  logic [6:0] data_in,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [2:0] weekday,
  output logic       leap,
  output logic       month_end,
  output logic       year_end,
  output logic       load_err
);

  // Field selects for the set path.
  localparam logic [1:0] SEL_DAY     = 2'b00;
  localparam logic [1:0] SEL_MONTH   = 2'b01;
  localparam logic [1:0] SEL_YEAR    = 2'b10;
  localparam logic [1:0] SEL_WEEKDAY = 2'b11;

  // Number of days in month m; lp selects the 29-day February.
  function automatic logic [4:0] dim_f(input logic [3:0] m, input logic lp);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = lp ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  logic [4:0] day_r,     day_s;
  logic [3:0] month_r,   month_s;
  logic [6:0] year_r,    year_s;
  logic [2:0] weekday_r, weekday_s;
  logic       month_end_r, month_end_s;
  logic       year_end_r,  year_end_s;
  logic       load_err_r,  load_err_s;
  logic       leap_s;
  logic [4:0] dim_cur_s;
  logic [4:0] dim_new_s;

  // The 2000-2099 window makes "divisible by four" the exact leap rule.
  assign leap_s    = (year_r[1:0] == 2'b00);
  assign dim_cur_s = dim_f(month_r, leap_s);
  assign dim_new_s = dim_f(data_in[3:0], leap_s);

  // Next-state: load has priority over tick; rejected loads change nothing.
  always_comb begin
    day_s       = day_r;
    month_s     = month_r;
    year_s      = year_r;
    weekday_s   = weekday_r;
    month_end_s = 1'b0;
    year_end_s  = 1'b0;
    load_err_s  = 1'b0;
    if (load) begin
      case (sel)
        SEL_DAY: begin
          if ((data_in >= 7'd1) && (data_in <= {2'b00, dim_cur_s})) begin
            day_s = data_in[4:0];
          end else begin
            load_err_s = 1'b1;
          end
        end
        SEL_MONTH: begin
          if ((data_in >= 7'd1) && (data_in <= 7'd12)) begin
            month_s = data_in[3:0];
            // Keep the date valid when moving to a shorter month.
            if (day_r > dim_new_s) begin
              day_s = dim_new_s;
            end else begin
              day_s = day_r;
            end
          end else begin
            load_err_s = 1'b1;
          end
        end
        SEL_YEAR: begin
          if (data_in <= 7'd99) begin
            year_s = data_in;
            // Feb 29 does not exist in the new year unless it is leap too.
            if ((month_r == 4'd2) && (day_r == 5'd29) && (data_in[1:0] != 2'b00)) begin
              day_s = 5'd28;
            end else begin
              day_s = day_r;
            end
          end else begin
            load_err_s = 1'b1;
          end
        end
        SEL_WEEKDAY: begin
          if (data_in <= 7'd6) begin
            weekday_s = data_in[2:0];
          end else begin
            load_err_s = 1'b1;
          end
        end
        default: begin
          load_err_s = 1'b1;
        end
      endcase
    end else if (day_tick) begin
      weekday_s = (weekday_r == 3'd6) ? 3'd0 : weekday_r + 3'd1;
      if (day_r < dim_cur_s) begin
        day_s = day_r + 5'd1;
      end else begin
        day_s       = 5'd1;
        month_end_s = 1'b1;
        if (month_r < 4'd12) begin
          month_s = month_r + 4'd1;
        end else begin
          month_s    = 4'd1;
          year_end_s = 1'b1;
          year_s     = (year_r == 7'd99) ? 7'd0 : year_r + 7'd1;
        end
      end
    end else begin
      day_s = day_r;
    end
  end

  // Date and pulse registers; clear_n forces the 2000-01-01 state at once.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      day_r       <= 5'd1;
      month_r     <= 4'd1;
      year_r      <= 7'd0;
      weekday_r   <= WEEKDAY_RST;
      month_end_r <= 1'b0;
      year_end_r  <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      day_r       <= day_s;
      month_r     <= month_s;
      year_r      <= year_s;
      weekday_r   <= weekday_s;
      month_end_r <= month_end_s;
      year_end_r  <= year_end_s;
      load_err_r  <= load_err_s;
    end
  end

  assign day       = day_r;
  assign month     = month_r;
  assign year      = year_r;
  assign weekday   = weekday_r;
  assign leap      = leap_s;
  assign month_end = month_end_r;
  assign year_end  = year_end_r;
  assign load_err  = load_err_r;

endmodule
